// File: rtl/mem_access_unit_if.sv
// Data-memory request bus between the MEM-stage access unit (master) and data memory (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane steering, extension, stall generation and bus timeout.
//   state  | meaning
//   S_IDLE | evaluate EX/MEM; issue aligned request or pass through
//   S_WAIT | request held on bus until ack or timeout
//   S_DONE | one cycle presenting captured load data to MEM/WB
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUOut_in,
    input  logic [31:0] StoreData_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        LoadSigned_in,
    input  logic        RegWrite_in,
    input  logic [4:0]  RegWriteAddr_in,
    input  logic [4:0]  Rd_in,
    input  logic [1:0]  RegDst_in,
    input  logic [1:0]  MemToReg_in,
    output logic [31:0] ALUOut_out,
    output logic [31:0] MemReadData_out,
    output logic        RegWrite_out,
    output logic [4:0]  RegWriteAddr_out,
    output logic [4:0]  Rd_out,
    output logic [1:0]  RegDst_out,
    output logic [1:0]  MemToReg_out,
    mem_access_unit_if.master dmem,
    output logic        mem_stall,
    output logic        misalign_exc,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_mem_op;
    logic        w_misalign;
    logic        w_timeout;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_mem_op  = MemRead_in | MemWrite_in;
    assign w_off     = ALUOut_in[1:0];
    assign w_timeout = (r_cnt == L_TIMEOUT);
    assign w_misalign = w_mem_op &
                        (((MemSize_in == 2'b01) & w_off[0]) |
                         (MemSize_in[1] & (w_off != 2'b00)));

    always_comb begin
        w_byte = dmem.dmem_rdata[7:0];
        case (w_off)
            2'd1:    w_byte = dmem.dmem_rdata[15:8];
            2'd2:    w_byte = dmem.dmem_rdata[23:16];
            2'd3:    w_byte = dmem.dmem_rdata[31:24];
            default: w_byte = dmem.dmem_rdata[7:0];
        endcase
        w_half = w_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (MemSize_in)
            2'b00:   w_load_data = {{24{LoadSigned_in & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{LoadSigned_in & w_half[15]}}, w_half};
            default: w_load_data = dmem.dmem_rdata;
        endcase
    end

    // Bus fields come straight from the frozen EX/MEM inputs, so they hold from request to ack.
    always_comb begin
        dmem.dmem_addr = {ALUOut_in[31:2], 2'b00};
        dmem.dmem_we   = MemWrite_in;
        case (MemSize_in)
            2'b00: begin
                dmem.dmem_be    = 4'b0001 << w_off;
                dmem.dmem_wdata = {4{StoreData_in[7:0]}};
            end
            2'b01: begin
                dmem.dmem_be    = w_off[1] ? 4'b1100 : 4'b0011;
                dmem.dmem_wdata = {2{StoreData_in[15:0]}};
            end
            default: begin
                dmem.dmem_be    = 4'b1111;
                dmem.dmem_wdata = StoreData_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_mem_op && !w_misalign) w_next_state = S_WAIT;
            S_WAIT:  if (dmem.dmem_ack || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
                S_WAIT: begin
                    if (dmem.dmem_ack) begin
                        r_rdata <= w_load_data;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ALUOut_out       = ALUOut_in;
        RegWriteAddr_out = RegWriteAddr_in;
        Rd_out           = Rd_in;
        RegDst_out       = RegDst_in;
        MemToReg_out     = MemToReg_in;
        RegWrite_out     = RegWrite_in;
        MemReadData_out  = '0;
        dmem.dmem_req    = 1'b0;
        mem_stall        = 1'b0;
        misalign_exc     = 1'b0;
        bus_err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    RegWrite_out = 1'b0;
                    if (w_misalign) begin
                        misalign_exc = 1'b1;
                    end else begin
                        dmem.dmem_req = 1'b1;
                        mem_stall     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                RegWrite_out  = 1'b0;
                dmem.dmem_req = 1'b1;
                mem_stall     = 1'b1;
                bus_err       = w_timeout & ~dmem.dmem_ack;
            end
            S_DONE: begin
                MemReadData_out = r_rdata;
                RegWrite_out    = RegWrite_in & ~MemWrite_in & ~r_err;
            end
            default: ;
        endcase
        // Reset drops the request and stall at once, even while the state is mid-access.
        if (!reset) begin
            dmem.dmem_req = 1'b0;
            mem_stall     = 1'b0;
            misalign_exc  = 1'b0;
            bus_err       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: driver queues expectations, negedge monitor checks.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUOut_in, StoreData_in;
    logic        MemRead_in, MemWrite_in, LoadSigned_in, RegWrite_in;
    logic [1:0]  MemSize_in, RegDst_in, MemToReg_in;
    logic [4:0]  RegWriteAddr_in, Rd_in;
    logic [31:0] ALUOut_out, MemReadData_out;
    logic        RegWrite_out;
    logic [4:0]  RegWriteAddr_out, Rd_out;
    logic [1:0]  RegDst_out, MemToReg_out;
    logic        mem_stall, misalign_exc, bus_err;

    mem_access_unit_if dif();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ALUOut_in(ALUOut_in), .StoreData_in(StoreData_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemSize_in(MemSize_in), .LoadSigned_in(LoadSigned_in),
        .RegWrite_in(RegWrite_in), .RegWriteAddr_in(RegWriteAddr_in),
        .Rd_in(Rd_in), .RegDst_in(RegDst_in), .MemToReg_in(MemToReg_in),
        .ALUOut_out(ALUOut_out), .MemReadData_out(MemReadData_out),
        .RegWrite_out(RegWrite_out), .RegWriteAddr_out(RegWriteAddr_out),
        .Rd_out(Rd_out), .RegDst_out(RegDst_out), .MemToReg_out(MemToReg_out),
        .dmem(dif),
        .mem_stall(mem_stall), .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mis;
        int          stall;
        int          berr;
        bit          rw;
        bit          chk_data;
        logic [31:0] data;
        logic [31:0] alu;
        logic [68:0] bus;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules as plain arithmetic on byte offsets.
    function automatic logic [31:0] ref_load(logic [31:0] rd, logic [31:0] a, logic [1:0] sz, bit sgn);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(logic [31:0] a, logic [1:0] sz);
        int b;
        if (sz == 2'd0)      b = 1 << (a % 4);
        else if (sz == 2'd1) b = 3 << (2 * ((a % 4) / 2));
        else                 b = 15;
        return 4'(b);
    endfunction

    function automatic logic [31:0] ref_wdata(logic [31:0] sd, logic [1:0] sz);
        if (sz == 2'd0) return (sd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic bit ref_misaligned(logic [31:0] a, logic [1:0] sz);
        return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
    endfunction

    task automatic set_nop();
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
    endtask

    task automatic rand_ctrl();
        RegWriteAddr_in = 5'($urandom);
        Rd_in           = 5'($urandom);
        RegDst_in       = 2'($urandom);
        MemToReg_in     = 2'($urandom);
    endtask

    // lat = WAIT cycle carrying the ack (1..TO); 0 means the memory never acks.
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                             input bit rw, input logic [31:0] a, input logic [31:0] sd,
                             input int lat, input logic [31:0] rdv);
        exp_t e;
        int   w;
        e.mis      = ref_misaligned(a, sz);
        e.stall    = (lat == 0) ? TO + 2 : lat + 1;
        e.berr     = (lat == 0) ? 1 : 0;
        e.rw       = (wr || lat == 0) ? 1'b0 : rw;
        e.chk_data = !wr;
        e.data     = (lat == 0) ? 32'h0 : ref_load(rdv, a, sz, sgn);
        e.alu      = a;
        e.bus      = {wr, ref_be(a, sz), a & 32'hFFFFFFFC, ref_wdata(sd, sz)};
        exp_q.push_back(e);
        rand_ctrl();
        ALUOut_in = a; StoreData_in = sd; MemSize_in = sz; LoadSigned_in = sgn;
        RegWrite_in = rw; MemRead_in = rd; MemWrite_in = wr;
        dif.dmem_ack = 1'($urandom); dif.dmem_rdata = $urandom;
        @(posedge clk); #1;
        if (!e.mis) begin
            w = 1;
            forever begin
                dif.dmem_ack   = (lat != 0 && w == lat);
                dif.dmem_rdata = dif.dmem_ack ? rdv : $urandom;
                @(posedge clk); #1;
                if ((lat != 0 && w == lat) || (lat == 0 && w == TO + 1)) break;
                w++;
            end
            dif.dmem_ack = 1'($urandom); dif.dmem_rdata = $urandom;
            @(posedge clk); #1;
        end
        dif.dmem_ack = 1'b0;
        set_nop();
    endtask

    task automatic chk_passthru();
        logic [31:0] a;
        a = $urandom;
        rand_ctrl();
        ALUOut_in = a; RegWrite_in = 1'($urandom); MemSize_in = 2'($urandom);
        StoreData_in = $urandom; set_nop();
        dif.dmem_ack = 1'($urandom);
        #1;
        chk("pt_alu", ALUOut_out, a);
        chk("pt_ctrl", {RegWrite_out, RegWriteAddr_out, Rd_out, RegDst_out, MemToReg_out},
            {RegWrite_in, RegWriteAddr_in, Rd_in, RegDst_in, MemToReg_in});
        chk("pt_rdata", MemReadData_out, 32'h0);
        chk("pt_req_stall", {dif.dmem_req, mem_stall}, 2'b00);
        @(posedge clk); #1;
        dif.dmem_ack = 1'b0;
    endtask

    // Monitor state
    exp_t        m_e;
    int          stall_cnt = 0, berr_cnt = 0;
    bit          prev_stall = 1'b0, req_seen = 1'b0;
    logic [68:0] s_bus;

    always @(negedge clk) begin
        if (!mon_en) begin
            stall_cnt = 0; berr_cnt = 0; prev_stall = 1'b0; req_seen = 1'b0;
        end else begin
            if (dif.dmem_req) begin
                if (!req_seen) begin
                    if (exp_q.size() == 0) chk("req_unexpected", 1'b1, 1'b0);
                    else chk("req_bus", {dif.dmem_we, dif.dmem_be, dif.dmem_addr, dif.dmem_wdata}, exp_q[0].bus);
                    s_bus    = {dif.dmem_we, dif.dmem_be, dif.dmem_addr, dif.dmem_wdata};
                    req_seen = 1'b1;
                end else begin
                    chk("bus_stable", {dif.dmem_we, dif.dmem_be, dif.dmem_addr, dif.dmem_wdata}, s_bus);
                end
            end
            if (mem_stall) begin
                stall_cnt++;
                if (bus_err) berr_cnt++;
                chk("rw_during_stall", RegWrite_out, 1'b0);
            end else begin
                chk("berr_outside_wait", bus_err, 1'b0);
            end
            if (misalign_exc) begin
                if (exp_q.size() == 0) chk("mis_unexpected", 1'b1, 1'b0);
                else begin
                    m_e = exp_q.pop_front();
                    chk("mis_kind", m_e.mis, 1'b1);
                    chk("mis_req_stall_rw", {dif.dmem_req, mem_stall, RegWrite_out}, 3'b000);
                end
            end
            if (!mem_stall && prev_stall) begin
                if (exp_q.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
                else begin
                    m_e = exp_q.pop_front();
                    chk("done_kind", m_e.mis, 1'b0);
                    chk("stall_len", stall_cnt, m_e.stall);
                    chk("berr_pulses", berr_cnt, m_e.berr);
                    chk("done_rw", RegWrite_out, m_e.rw);
                    chk("done_alu", ALUOut_out, m_e.alu);
                    chk("done_req", dif.dmem_req, 1'b0);
                    if (m_e.chk_data) chk("done_rdata", MemReadData_out, m_e.data);
                end
                stall_cnt = 0; berr_cnt = 0; req_seen = 1'b0;
            end
            prev_stall = mem_stall;
        end
    end

    task automatic reset_midwait();
        mon_en = 1'b0;
        rand_ctrl();
        ALUOut_in = 32'h100; MemSize_in = 2'd2; RegWrite_in = 1'b1; LoadSigned_in = 1'b0;
        MemRead_in = 1'b1; MemWrite_in = 1'b0; dif.dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 reset = 1'b0;
        #1;
        chk("rst_async_drop", {dif.dmem_req, mem_stall, misalign_exc, bus_err}, 4'b0000);
        set_nop();
        @(posedge clk); #1;
        reset = 1'b1;
        dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_ignored", {mem_stall, dif.dmem_req, MemReadData_out}, 34'h0);
        end
        @(posedge clk); #1;
        dif.dmem_ack = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rd, wr;
        logic [1:0]  sz;
        logic [31:0] a;
        int          lat;
        reset = 1'b0;
        rand_ctrl();
        ALUOut_in = 32'h100; StoreData_in = 32'h0; MemSize_in = 2'd2; LoadSigned_in = 1'b0;
        RegWrite_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
        dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hFFFFFFFF;
        #12;
        chk("reset_outputs", {dif.dmem_req, mem_stall, misalign_exc, bus_err, MemReadData_out}, 36'h0);
        set_nop(); dif.dmem_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (3) chk_passthru();

        do_access(1, 0, 2'd2, 0, 1, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        do_access(1, 0, 2'd0, 1, 1, 32'h103, 32'h0, 1, 32'h80FFFFFF);
        do_access(1, 0, 2'd0, 0, 1, 32'h103, 32'h0, 2, 32'h80FFFFFF);
        do_access(0, 1, 2'd1, 0, 1, 32'h202, 32'h0000ABCD, 2, 32'h55555555);
        do_access(1, 0, 2'd2, 0, 1, 32'h101, 32'h0, 1, 32'h0);
        do_access(1, 0, 2'd2, 0, 1, 32'h300, 32'h0, 0, 32'h0);
        do_access(1, 1, 2'd2, 0, 1, 32'h400, 32'hCAFEF00D, 1, 32'h11111111);
        do_access(1, 0, 2'd1, 1, 1, 32'h506, 32'h0, 4, 32'h9ABC1234);
        reset_midwait();
        chk_passthru();

        for (int t = 0; t < 60; t++) begin
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            sz  = 2'($urandom);
            a   = ($urandom & 32'hFFFFFFFC) | ($urandom % 4);
            lat = ($urandom % 6 == 0) ? 0 : 1 + ($urandom % TO);
            do_access(rd, wr, sz, 1'($urandom), 1'($urandom), a, $urandom, lat, $urandom);
            repeat ($urandom % 3) begin
                dif.dmem_ack = 1'($urandom); dif.dmem_rdata = $urandom;
                @(posedge clk); #1;
            end
            dif.dmem_ack = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
